// File: rtl/iterative_mdu_pkg.sv
// Shared control-unit op codes and MDU types.
// ALU and MDU codes live in one space so execute can route on op alone.
package iterative_mdu_pkg;

  localparam logic [5:0] CU_ADD  = 6'h00;
  localparam logic [5:0] CU_SUB  = 6'h01;
  localparam logic [5:0] CU_AND  = 6'h02;
  localparam logic [5:0] CU_OR   = 6'h03;
  localparam logic [5:0] CU_XOR  = 6'h04;
  localparam logic [5:0] CU_SLL  = 6'h05;
  localparam logic [5:0] CU_SRL  = 6'h06;
  localparam logic [5:0] CU_SRA  = 6'h07;
  localparam logic [5:0] CU_SLT  = 6'h08;
  localparam logic [5:0] CU_SLTU = 6'h09;

  localparam logic [5:0] CU_MUL    = 6'h10;
  localparam logic [5:0] CU_MULH   = 6'h11;
  localparam logic [5:0] CU_MULHSU = 6'h12;
  localparam logic [5:0] CU_MULHU  = 6'h13;
  localparam logic [5:0] CU_DIV    = 6'h14;
  localparam logic [5:0] CU_DIVU   = 6'h15;
  localparam logic [5:0] CU_REM    = 6'h16;
  localparam logic [5:0] CU_REMU   = 6'h17;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } mdu_state_t;

  typedef struct packed {
    logic valid;
    logic mul;
    logic div;
    logic rem;
    logic hi;
    logic sa;
    logic sb;
  } mdu_dec_t;

endpackage

// File: rtl/iterative_mdu_iter_step.sv
// One iteration of the shared datapath:
// add-shift right (multiply) or restoring subtract-shift left (divide).
module mdu_iter_step #(
  parameter int XLEN = 32
) (
  input  logic            mode_mul,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opr,
  output logic [XLEN-1:0] hi_n,
  output logic [XLEN-1:0] lo_n
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN+1:0] diff;
  logic            nb;

  always_comb begin
    sum    = {1'b0, hi} + (lo[0] ? {1'b0, opr} : '0);
    rem_sh = {hi, lo[XLEN-1]};
    diff   = {1'b0, rem_sh} - {2'b00, opr};
    nb     = !diff[XLEN+1];
    if (mode_mul) begin
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], lo[XLEN-1:1]};
    end else begin
      hi_n = nb ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
      lo_n = {lo[XLEN-2:0], nb};
    end
  end

endmodule

// File: rtl/iterative_mdu.sv
// Multi-cycle RV32M multiply/divide unit with valid/ready handshake.
// Works on magnitudes; the sign fix-up happens in one FIX cycle.
module iterative_mdu
  import iterative_mdu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OPW  = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            in_ready,
  input  logic [OPW-1:0]  op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [XLEN-1:0] result,
  output logic            negative,
  output logic            zero,
  output logic            busy
);

  localparam int CNTW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_S = {1'b1, {(XLEN-1){1'b0}}};

  function automatic mdu_dec_t decode(input logic [OPW-1:0] o);
    mdu_dec_t d;
    d = '0;
    d.valid = 1'b1;
    case (o)
      OPW'(CU_MUL):    d.mul = 1'b1;
      OPW'(CU_MULH):   begin d.mul = 1'b1; d.hi = 1'b1; d.sa = 1'b1; d.sb = 1'b1; end
      OPW'(CU_MULHSU): begin d.mul = 1'b1; d.hi = 1'b1; d.sa = 1'b1; end
      OPW'(CU_MULHU):  begin d.mul = 1'b1; d.hi = 1'b1; end
      OPW'(CU_DIV):    begin d.div = 1'b1; d.sa = 1'b1; d.sb = 1'b1; end
      OPW'(CU_DIVU):   d.div = 1'b1;
      OPW'(CU_REM):    begin d.rem = 1'b1; d.sa = 1'b1; d.sb = 1'b1; end
      OPW'(CU_REMU):   d.rem = 1'b1;
      default:         d.valid = 1'b0;
    endcase
    return d;
  endfunction

  mdu_state_t       state;
  mdu_dec_t         dec_in, dec_q;
  logic [XLEN-1:0]  hi_q, lo_q, opr_q;
  logic [XLEN-1:0]  hi_n, lo_n;
  logic [CNTW-1:0]  cnt;
  logic             neg_q;

  logic             a_neg, b_neg, divop, b_zero, ovf, bypass;
  logic [XLEN-1:0]  a_mag, b_mag, byp_res;
  logic [2*XLEN-1:0] prod, prod_f;
  logic [XLEN-1:0]  quo, rmd, fix_res;

  always_comb begin
    dec_in = decode(op);
    a_neg  = dec_in.sa & operand_a[XLEN-1];
    b_neg  = dec_in.sb & operand_b[XLEN-1];
    a_mag  = a_neg ? -operand_a : operand_a;
    b_mag  = b_neg ? -operand_b : operand_b;
    divop  = dec_in.div | dec_in.rem;
    b_zero = operand_b == '0;
    ovf    = dec_in.sb & divop & (operand_a == MIN_S) & (&operand_b);
    bypass = !dec_in.valid | (divop & (b_zero | ovf));
    byp_res = '0;
    if (dec_in.valid && divop && b_zero)
      byp_res = dec_in.div ? '1 : operand_a;
    else if (dec_in.valid && ovf)
      byp_res = dec_in.div ? MIN_S : '0;
  end

  mdu_iter_step #(
    .XLEN(XLEN)
  ) u_step (
    .mode_mul(dec_q.mul),
    .hi      (hi_q),
    .lo      (lo_q),
    .opr     (opr_q),
    .hi_n    (hi_n),
    .lo_n    (lo_n)
  );

  always_comb begin
    prod   = {hi_q, lo_q};
    prod_f = neg_q ? -prod : prod;
    quo    = neg_q ? -lo_q : lo_q;
    rmd    = neg_q ? -hi_q : hi_q;
    unique case (1'b1)
      dec_q.mul & !dec_q.hi: fix_res = prod_f[XLEN-1:0];
      dec_q.mul &  dec_q.hi: fix_res = prod_f[2*XLEN-1:XLEN];
      dec_q.div:             fix_res = quo;
      dec_q.rem:             fix_res = rmd;
      default:               fix_res = '0;
    endcase
  end

  assign in_ready = state == IDLE;
  assign busy     = (state == CALC) | (state == FIX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      result       <= '0;
      result_valid <= 1'b0;
      negative     <= 1'b0;
      zero         <= 1'b0;
      dec_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      opr_q        <= '0;
      neg_q        <= 1'b0;
      cnt          <= '0;
    end else if (flush) begin
      state        <= IDLE;
      result_valid <= 1'b0;
      negative     <= 1'b0;
      zero         <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          dec_q <= dec_in;
          neg_q <= dec_in.rem ? a_neg : (a_neg ^ b_neg);
          cnt   <= '0;
          hi_q  <= '0;
          lo_q  <= dec_in.mul ? b_mag : a_mag;
          opr_q <= dec_in.mul ? a_mag : b_mag;
          if (bypass) begin
            state        <= DONE;
            result       <= byp_res;
            result_valid <= 1'b1;
            negative     <= byp_res[XLEN-1];
            zero         <= byp_res == '0;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          hi_q <= hi_n;
          lo_q <= lo_n;
          cnt  <= cnt + CNTW'(1);
          if (cnt == CNTW'(XLEN - 1))
            state <= FIX;
        end
        FIX: begin
          state        <= DONE;
          result       <= fix_res;
          result_valid <= 1'b1;
          negative     <= fix_res[XLEN-1];
          zero         <= fix_res == '0;
        end
        DONE: if (result_ready) begin
          state        <= IDLE;
          result_valid <= 1'b0;
          negative     <= 1'b0;
          zero         <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_mdu.sv
// Self-checking bench for iterative_mdu: directed RV32M corner cases,
// randomized ops against an arithmetic model, handshake/flush/reset scenarios.
module tb_iterative_mdu;
  import iterative_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_ready;
  logic [5:0]  op = '0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        flush = 1'b0;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic [31:0] result;
  logic        negative;
  logic        zero;
  logic        busy;

  int checks = 0;
  int failures = 0;

  localparam int LAT_N = 34;
  localparam int LAT_B = 1;

  iterative_mdu #(.XLEN(32), .OPW(6)) dut (
    .clk(clk), .rst(rst), .start(start), .in_ready(in_ready),
    .op(op), .operand_a(operand_a), .operand_b(operand_b),
    .flush(flush), .result_valid(result_valid),
    .result_ready(result_ready), .result(result),
    .negative(negative), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [5:0] o,
                                        input logic [31:0] a, b);
    longint sa, sb, ua, ub, p;
    logic [63:0] up;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ia = a;
    ib = b;
    case (o)
      CU_MUL:    begin p = sa * sb; return p[31:0]; end
      CU_MULH:   begin p = sa * sb; return p[63:32]; end
      CU_MULHSU: begin p = sa * ub; return p[63:32]; end
      CU_MULHU:  begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      CU_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      CU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      CU_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      CU_REMU: return (b == 0) ? a : a % b;
      default: begin
        if (ua < 0 || ub < 0) return 32'h0;
        return 32'h0;
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [5:0] o,
                                   input logic [31:0] a, b);
    if (o < CU_MUL || o > CU_REMU) return LAT_B;
    if (o >= CU_DIV && b == 0) return LAT_B;
    if ((o == CU_DIV || o == CU_REM) &&
        a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return LAT_B;
    return LAT_N;
  endfunction

  task automatic do_op(input logic [5:0] o, input logic [31:0] a, b,
                       output logic [31:0] r, output logic n, z,
                       output int lat);
    @(negedge clk);
    op = o;
    operand_a = a;
    operand_b = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 6'($urandom);
    operand_a = $urandom;
    operand_b = $urandom;
    lat = 1;
    while (!result_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r = result;
    n = negative;
    z = zero;
  endtask

  task automatic retire();
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({result_valid, negative, zero, busy, in_ready} !== 5'b00001 ||
        result !== 32'h0) begin
      failures++;
      $display("FAIL reset: valid=%b neg=%b zero=%b busy=%b rdy=%b res=%h, want 0 0 0 0 1 0",
               result_valid, negative, zero, busy, in_ready, result);
    end
  endtask

  typedef struct {
    logic [5:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
    int          l;
  } vec_t;

  task automatic test_directed();
    vec_t v[14];
    logic [31:0] r;
    logic n, z;
    int lat;
    v[0]  = '{CU_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_N};
    v[1]  = '{CU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT_N};
    v[2]  = '{CU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_N};
    v[3]  = '{CU_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, LAT_N};
    v[4]  = '{CU_DIV,    32'hFFFF_FFEC, 32'd6,         32'hFFFF_FFFD, LAT_N};
    v[5]  = '{CU_REM,    32'hFFFF_FFEC, 32'd6,         32'hFFFF_FFFE, LAT_N};
    v[6]  = '{CU_DIVU,   32'd20,        32'd6,         32'd3,         LAT_N};
    v[7]  = '{CU_REMU,   32'd20,        32'd6,         32'd2,         LAT_N};
    v[8]  = '{CU_DIVU,   32'h1234,      32'd0,         32'hFFFF_FFFF, LAT_B};
    v[9]  = '{CU_REM,    32'h1234,      32'd0,         32'h1234,      LAT_B};
    v[10] = '{CU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_B};
    v[11] = '{CU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         LAT_B};
    v[12] = '{6'h3F,     32'd5,         32'd5,         32'h0,         LAT_B};
    v[13] = '{CU_MUL,    32'd0,         32'd12345,     32'h0,         LAT_N};
    for (int i = 0; i < 14; i++) begin
      do_op(v[i].o, v[i].a, v[i].b, r, n, z, lat);
      checks++;
      if (r !== v[i].e || lat !== v[i].l) begin
        failures++;
        $display("FAIL directed[%0d]: res=%h lat=%0d, want res=%h lat=%0d",
                 i, r, lat, v[i].e, v[i].l);
      end
      checks++;
      if (n !== v[i].e[31] || z !== (v[i].e == 0)) begin
        failures++;
        $display("FAIL directed_flags[%0d]: neg=%b zero=%b, want %b %b",
                 i, n, z, v[i].e[31], v[i].e == 0);
      end
      retire();
      checks++;
      if (result_valid !== 1'b0 || in_ready !== 1'b1 ||
          negative !== 1'b0 || zero !== 1'b0) begin
        failures++;
        $display("FAIL retire[%0d]: valid=%b rdy=%b neg=%b zero=%b, want 0 1 0 0",
                 i, result_valid, in_ready, negative, zero);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] ops[8] = '{CU_MUL, CU_MULH, CU_MULHSU, CU_MULHU,
                           CU_DIV, CU_DIVU, CU_REM, CU_REMU};
    logic [5:0]  o;
    logic [31:0] a, b, e, r;
    logic n, z;
    int lat, el, bad;
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      o = ops[$urandom_range(0, 7)];
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
        3: b = $urandom_range(1, 9) | 32'hFFFF_FFF0;
        4: o = 6'($urandom_range(32, 63));
        default: ;
      endcase
      e = model(o, a, b);
      el = model_lat(o, a, b);
      do_op(o, a, b, r, n, z, lat);
      checks++;
      if (r !== e || lat !== el || n !== e[31] || z !== (e == 0)) begin
        failures++;
        if (bad < 10)
          $display("FAIL random op=%h a=%h b=%h: res=%h lat=%0d n=%b z=%b, want %h %0d %b %b",
                   o, a, b, r, lat, n, z, e, el, e[31], e == 0);
        bad++;
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      retire();
    end
  endtask

  task automatic test_hold();
    logic [31:0] r;
    logic n, z;
    int lat;
    do_op(CU_DIVU, 32'd100, 32'd7, r, n, z, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'b1;
      op = CU_MUL;
      operand_a = $urandom;
      operand_b = $urandom;
      @(posedge clk);
      #1;
      checks++;
      if (result_valid !== 1'b1 || result !== 32'd14 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold[%0d]: valid=%b res=%h rdy=%b, want 1 0000000e 0",
                 i, result_valid, result, in_ready);
      end
    end
    @(negedge clk);
    start = 1'b0;
    retire();
    checks++;
    if (result_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL hold_release: valid=%b rdy=%b busy=%b, want 0 1 0",
               result_valid, in_ready, busy);
    end
  endtask

  task automatic accept(input logic [5:0] o, input logic [31:0] a, b);
    @(negedge clk);
    op = o;
    operand_a = a;
    operand_b = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_flush();
    logic [31:0] r;
    logic n, z;
    int lat, seen;
    accept(CU_MUL, 32'd1234, 32'd5678);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL busy_calc: busy=%b rdy=%b, want 1 0", busy, in_ready);
    end
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_calc: rdy=%b busy=%b valid=%b, want 1 0 0",
               in_ready, busy, result_valid);
    end
    accept(CU_DIV, 32'd999, 32'd3);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || result_valid !== 1'b0 || result !== 32'h0) begin
      failures++;
      $display("FAIL rst_calc: rdy=%b valid=%b res=%h, want 1 0 0",
               in_ready, result_valid, result);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (result_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL no_result_after_abort: valid cycles=%0d, want 0", seen);
    end
    do_op(CU_MULHU, 32'hFFFF_0000, 32'hFFFF_0000, r, n, z, lat);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || in_ready !== 1'b1 ||
        negative !== 1'b0 || zero !== 1'b0) begin
      failures++;
      $display("FAIL flush_done: valid=%b rdy=%b neg=%b zero=%b, want 0 1 0 0",
               result_valid, in_ready, negative, zero);
    end
    @(negedge clk);
    start = 1'b1;
    flush = 1'b1;
    op = CU_MUL;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL start_flush_idle: rdy=%b busy=%b valid=%b, want 1 0 0",
               in_ready, busy, result_valid);
    end
    do_op(CU_REMU, 32'd50, 32'd7, r, n, z, lat);
    retire();
    accept(CU_MUL, 32'd9, 32'd9);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    flush = 1'b0;
    checks++;
    if (result !== 32'h0 || in_ready !== 1'b1 || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_flush: res=%h rdy=%b valid=%b, want 0 1 0",
               result, in_ready, result_valid);
    end
    do_op(CU_MUL, 32'd3, 32'd4, r, n, z, lat);
    checks++;
    if (r !== 32'd12 || lat !== LAT_N || n !== 1'b0 || z !== 1'b0) begin
      failures++;
      $display("FAIL mul_after_abort: res=%h lat=%0d n=%b z=%b, want 0000000c %0d 0 0",
               r, lat, n, z, LAT_N);
    end
    retire();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
